// File: rtl/sine_pkg.sv
// Shared widths and the quarter-wave sine table for the DAC sine generator.
// Table entry i is round(511*sin(2*pi*(i+0.5)/512)) and is monotonic over 0..127.
package sine_pkg;

  localparam int PHASE_W = 9;
  localparam int ROM_AW  = 7;
  localparam int DAC_W   = 10;
  localparam int Q_W     = 9;

  localparam int QROM [128] = '{
      3,   9,  16,  22,  28,  34,  41,  47,
     53,  59,  66,  72,  78,  84,  90,  97,
    103, 109, 115, 121, 127, 133, 139, 145,
    151, 157, 163, 169, 175, 181, 187, 193,
    198, 204, 210, 216, 221, 227, 233, 238,
    244, 249, 255, 260, 265, 271, 276, 281,
    286, 292, 297, 302, 307, 312, 317, 322,
    327, 331, 336, 341, 345, 350, 355, 359,
    364, 368, 372, 377, 381, 385, 389, 393,
    397, 401, 405, 409, 412, 416, 420, 423,
    427, 430, 433, 437, 440, 443, 446, 449,
    452, 455, 458, 461, 463, 466, 468, 471,
    473, 476, 478, 480, 482, 484, 486, 488,
    490, 492, 493, 495, 496, 498, 499, 501,
    502, 503, 504, 505, 506, 507, 508, 508,
    509, 509, 510, 510, 511, 511, 511, 511
  };

endpackage

// File: rtl/sine_quarter_rom.sv
// Combinational quarter-wave lookup: 7-bit index to 9-bit unsigned magnitude.
module sine_quarter_rom
  import sine_pkg::*;
(
  input  logic [ROM_AW-1:0] addr,
  output logic [Q_W-1:0]    q
);

  assign q = Q_W'(QROM[addr]);

endmodule

// File: rtl/sine_dac_gen.sv
// Free-running sine generator for a 10-bit R-2R DAC on ten discrete pins.
// A phase counter stepped every DIV clocks folds into the quarter-wave table.
module sine_dac_gen
  import sine_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic _9b,
  output logic _6a,
  output logic _4a,
  output logic _2a,
  output logic _0a,
  output logic _5a,
  output logic _3b,
  output logic _49a,
  output logic _45a,
  output logic _48b
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [DAC_W-1:0]   dout_q, dout_d;
  logic [ROM_AW-1:0]  rom_addr;
  logic [Q_W-1:0]     rom_q;

  sine_quarter_rom u_rom (
    .addr (rom_addr),
    .q    (rom_q)
  );

  // Odd quadrants read the table backwards; the upper half mirrors around mid-scale.
  always_comb begin
    rom_addr  = phase_q[7] ? ~phase_q[6:0] : phase_q[6:0];
    dout_d    = phase_q[8] ? (DAC_W'(511) - DAC_W'(rom_q))
                           : (DAC_W'(512) + DAC_W'(rom_q));
    div_cnt_d = div_cnt_q + DIV_W'(1);
    phase_d   = phase_q;
    if (div_cnt_q == DIV_W'(DIV - 1)) begin
      div_cnt_d = '0;
      phase_d   = phase_q + PHASE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      div_cnt_q <= '0;
      dout_q    <= '0;
    end else begin
      phase_q   <= phase_d;
      div_cnt_q <= div_cnt_d;
      dout_q    <= dout_d;
    end
  end

  assign {_48b, _45a, _49a, _3b, _5a, _0a, _2a, _4a, _6a, _9b} = dout_q;

endmodule

// File: tb/tb_sine_dac_gen.sv
// Scoreboard bench for sine_dac_gen: DIV=1 and DIV=4 instances against a $sin model.
module tb_sine_dac_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire [9:0] d1;
  wire [9:0] d4;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int cap[1024];

  always #40 clk = ~clk;

  sine_dac_gen #(.DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    ._9b(d1[0]), ._6a(d1[1]), ._4a(d1[2]), ._2a(d1[3]), ._0a(d1[4]),
    ._5a(d1[5]), ._3b(d1[6]), ._49a(d1[7]), ._45a(d1[8]), ._48b(d1[9])
  );

  sine_dac_gen #(.DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    ._9b(d4[0]), ._6a(d4[1]), ._4a(d4[2]), ._2a(d4[3]), ._0a(d4[4]),
    ._5a(d4[5]), ._3b(d4[6]), ._49a(d4[7]), ._45a(d4[8]), ._48b(d4[9])
  );

  function automatic int q_model(int i);
    real th;
    th = 2.0 * 3.14159265358979 * (real'(i) + 0.5) / 512.0;
    return $rtoi(511.0 * $sin(th) + 0.5);
  endfunction

  function automatic int s_model(int p);
    int i;
    i = p & 127;
    case ((p >> 7) & 3)
      0:       return 512 + q_model(i);
      1:       return 512 + q_model(127 - i);
      2:       return 511 - q_model(i);
      default: return 511 - q_model(127 - i);
    endcase
  endfunction

  task automatic restart();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (d1 !== 10'd0) begin n_err++; $display("FAIL reset_div1 got %0d want 0", d1); end
    n_cmp++; if (d4 !== 10'd0) begin n_err++; $display("FAIL reset_div4 got %0d want 0", d4); end
  endtask

  task automatic test_full_period();
    int e;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      exp_q.push_back(s_model(k % 512));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (d1 !== 10'(e)) begin
        n_err++; $display("FAIL full_period edge=%0d got %0d want %0d", k + 1, d1, e);
      end
      cap[k] = int'(d1);
    end
    n_cmp++; if (cap[0] != 515)  begin n_err++; $display("FAIL first_edge got %0d want 515", cap[0]); end
    n_cmp++; if (cap[1] != 521)  begin n_err++; $display("FAIL second_edge got %0d want 521", cap[1]); end
    n_cmp++; if (cap[127] != 1023) begin n_err++; $display("FAIL peak127 got %0d want 1023", cap[127]); end
    n_cmp++; if (cap[128] != 1023) begin n_err++; $display("FAIL peak128 got %0d want 1023", cap[128]); end
    n_cmp++; if (cap[383] != 0)  begin n_err++; $display("FAIL min383 got %0d want 0", cap[383]); end
    n_cmp++; if (cap[384] != 0)  begin n_err++; $display("FAIL min384 got %0d want 0", cap[384]); end
    n_cmp++; if (cap[256] != 508) begin n_err++; $display("FAIL mid256 got %0d want 508", cap[256]); end
    for (int k = 0; k < 512; k++) begin
      n_cmp++;
      if (cap[k + 512] != cap[k]) begin
        n_err++; $display("FAIL wrap_repeat k=%0d got %0d want %0d", k, cap[k + 512], cap[k]);
      end
    end
  endtask

  task automatic test_symmetry();
    for (int p = 0; p < 512; p++) begin
      n_cmp++;
      if (cap[p] + cap[p ^ 256] != 1023) begin
        n_err++; $display("FAIL sym_half p=%0d got %0d want 1023", p, cap[p] + cap[p ^ 256]);
      end
    end
    for (int p = 0; p < 256; p++) begin
      n_cmp++;
      if (cap[p] != cap[255 - p]) begin
        n_err++; $display("FAIL sym_mirror p=%0d got %0d want %0d", p, cap[p], cap[255 - p]);
      end
    end
  endtask

  task automatic test_div4();
    int e;
    restart();
    for (int k = 1; k <= 2056; k++) begin
      exp_q.push_back(s_model(((k - 1) / 4) % 512));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (d4 !== 10'(e)) begin
        n_err++; $display("FAIL div4 edge=%0d got %0d want %0d", k, d4, e);
      end
    end
  endtask

  task automatic test_async_reset();
    int e;
    restart();
    for (int k = 0; k < 300; k++) begin
      exp_q.push_back(s_model(k));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (d1 !== 10'(e)) begin
        n_err++; $display("FAIL pre_reset edge=%0d got %0d want %0d", k + 1, d1, e);
      end
    end
    #20 rst_n = 1'b0;
    #5;
    n_cmp++; if (d1 !== 10'd0) begin n_err++; $display("FAIL async_div1 got %0d want 0", d1); end
    n_cmp++; if (d4 !== 10'd0) begin n_err++; $display("FAIL async_div4 got %0d want 0", d4); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(s_model(k));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (d1 !== 10'(e)) begin
        n_err++; $display("FAIL restart edge=%0d got %0d want %0d", k + 1, d1, e);
      end
    end
  endtask

  task automatic test_long_run();
    int e;
    restart();
    for (int k = 0; k < 1250; k++) begin
      exp_q.push_back(s_model(k % 512));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ($isunknown(d1) || $isunknown(d4)) begin
        n_err++; $display("FAIL long_xz edge=%0d got %b/%b want known", k + 1, d1, d4);
      end else if (d1 !== 10'(e)) begin
        n_err++; $display("FAIL long_run edge=%0d got %0d want %0d", k + 1, d1, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_period();
    test_symmetry();
    test_div4();
    test_async_reset();
    test_long_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
